// File: rtl/jump_pkg.sv
// Shared definitions for the jump resolution station: compare codes,
// FSM state encoding, JALR op bit and the "tag zero means ready" constant.
// Imported by jump_resolve_unit and jru_cdb_snoop.
package jump_pkg;

  // Branch compare codes carried in jump_op[2:0]
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  // jump_op bit selecting JALR over JAL for unconditional jumps
  localparam int JALR_BIT = 3;

  // A producer tag of this value means the operand value is already present
  localparam int TAG_READY = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } jru_state_t;

endpackage

// File: rtl/jru_cdb_snoop.sv
// Priority matcher of one operand tag against NUM_CDB result buses.
// Ports: tag (operand producer tag), cdb_valid/cdb_tag/cdb_data (packed buses),
//        hit (some valid bus carries this tag), data (value from lowest matching bus).
module jru_cdb_snoop
  import jump_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int NUM_CDB = 2
) (
  input  logic [TAG_W-1:0]         tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);

  // Scan from the highest bus down so the lowest-index match is the last write.
  // A ready tag never matches, even if a bus happens to broadcast tag zero.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (tag != TAG_W'(TAG_READY)) &&
          (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
        hit  = 1'b1;
        data = cdb_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/jump_resolve_unit.sv
// Single-entry branch/JAL/JALR resolution station: holds an issued jump until
// its operands are valid (register values or CDB snoop), then emits a one-cycle
// registered redirect. Ports: issue bus in, packed CDB in, flush in;
// issue_ready/jump_stall and redirect_* / link_data out.
// Optional macro JUMP_RESOLVE_PERF_EN adds perf_branches/perf_taken/perf_wait_cycles.
module jump_resolve_unit
  import jump_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     branch_issue,
  input  logic                     ujump_issue,
  input  logic [3:0]               jump_op,
  input  logic [TAG_W-1:0]         q_rs1,
  input  logic [TAG_W-1:0]         q_rs2,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [XLEN-1:0]          imm,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  input  logic                     flush,
`ifdef JUMP_RESOLVE_PERF_EN
  output logic [31:0]              perf_branches,
  output logic [31:0]              perf_taken,
  output logic [31:0]              perf_wait_cycles,
`endif
  output logic                     issue_ready,
  output logic                     jump_stall,
  output logic                     redirect_valid,
  output logic                     redirect_taken,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [XLEN-1:0]          link_data
);

  jru_state_t state;

  // Held entry
  logic             br_r, jalr_r;
  logic [2:0]       cmp_r;
  logic [XLEN-1:0]  pc_r, imm_r, d1_r, d2_r;
  logic [TAG_W-1:0] q1_r, q2_r;

  // Registered redirect outputs, only nonzero in DONE
  logic             rv_r, taken_r;
  logic [XLEN-1:0]  rpc_r, link_r;

  logic in_idle, issue;
  assign in_idle = (state == ST_IDLE);
  assign issue   = branch_issue | ujump_issue;

  // In IDLE the unit looks at the issue bus (capture cycle); otherwise at the entry.
  logic             cur_br, cur_jalr;
  logic [2:0]       cur_cmp;
  logic [XLEN-1:0]  cur_pc, cur_imm, src_d1, src_d2;
  logic [TAG_W-1:0] src_q1, src_q2;

  assign cur_br   = in_idle ? branch_issue : br_r;
  assign cur_jalr = in_idle ? (!branch_issue && jump_op[JALR_BIT]) : jalr_r;
  assign cur_cmp  = in_idle ? jump_op[2:0] : cmp_r;
  assign cur_pc   = in_idle ? pc       : pc_r;
  assign cur_imm  = in_idle ? imm      : imm_r;
  assign src_q1   = in_idle ? q_rs1    : q1_r;
  assign src_q2   = in_idle ? q_rs2    : q2_r;
  assign src_d1   = in_idle ? rs1_data : d1_r;
  assign src_d2   = in_idle ? rs2_data : d2_r;

  logic            hit1, hit2;
  logic [XLEN-1:0] cdb_d1, cdb_d2;

  jru_cdb_snoop #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_snoop_rs1 (
    .tag(src_q1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .hit(hit1), .data(cdb_d1)
  );

  jru_cdb_snoop #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_snoop_rs2 (
    .tag(src_q2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .hit(hit2), .data(cdb_d2)
  );

  logic            rdy1, rdy2, need1, need2, all_rdy;
  logic [XLEN-1:0] op1, op2;

  assign rdy1    = (src_q1 == TAG_W'(TAG_READY)) || hit1;
  assign rdy2    = (src_q2 == TAG_W'(TAG_READY)) || hit2;
  assign op1     = hit1 ? cdb_d1 : src_d1;
  assign op2     = hit2 ? cdb_d2 : src_d2;
  assign need1   = cur_br || cur_jalr;
  assign need2   = cur_br;
  assign all_rdy = (!need1 || rdy1) && (!need2 || rdy2);

  // Resolution datapath, evaluated on the cycle the last operand becomes ready
  logic            cmp_res, res_taken;
  logic [XLEN-1:0] jalr_sum, res_target, res_link;

  always_comb begin
    unique case (cur_cmp)
      CMP_EQ:  cmp_res = (op1 == op2);
      CMP_NE:  cmp_res = (op1 != op2);
      CMP_LT:  cmp_res = ($signed(op1) <  $signed(op2));
      CMP_GE:  cmp_res = ($signed(op1) >= $signed(op2));
      CMP_LTU: cmp_res = (op1 <  op2);
      CMP_GEU: cmp_res = (op1 >= op2);
      default: cmp_res = 1'b0;
    endcase
  end

  assign jalr_sum   = op1 + cur_imm;
  assign res_target = cur_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (cur_pc + cur_imm);
  assign res_taken  = cur_br ? cmp_res : 1'b1;
  assign res_link   = cur_br ? '0 : (cur_pc + XLEN'(4));

  assign issue_ready = in_idle;
  assign jump_stall  = !in_idle || (issue && !all_rdy);

  // A flush landing on the DONE cycle cancels the pulse combinationally.
  assign redirect_valid = rv_r && !flush;
  assign redirect_taken = taken_r && !flush;
  assign redirect_pc    = flush ? '0 : rpc_r;
  assign link_data      = flush ? '0 : link_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      br_r    <= 1'b0;
      jalr_r  <= 1'b0;
      cmp_r   <= '0;
      pc_r    <= '0;
      imm_r   <= '0;
      d1_r    <= '0;
      d2_r    <= '0;
      q1_r    <= '0;
      q2_r    <= '0;
      rv_r    <= 1'b0;
      taken_r <= 1'b0;
      rpc_r   <= '0;
      link_r  <= '0;
    end else begin
      // Operand forwarding into the entry every cycle it is being filled or held
      if (in_idle || state == ST_WAIT) begin
        q1_r <= hit1 ? TAG_W'(TAG_READY) : src_q1;
        q2_r <= hit2 ? TAG_W'(TAG_READY) : src_q2;
        d1_r <= op1;
        d2_r <= op2;
      end
      case (state)
        ST_IDLE: begin
          if (issue && !flush) begin
            br_r   <= cur_br;
            jalr_r <= cur_jalr;
            cmp_r  <= cur_cmp;
            pc_r   <= pc;
            imm_r  <= imm;
            if (all_rdy) begin
              state   <= ST_DONE;
              rv_r    <= 1'b1;
              taken_r <= res_taken;
              rpc_r   <= res_target;
              link_r  <= res_link;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (all_rdy) begin
            state   <= ST_DONE;
            rv_r    <= 1'b1;
            taken_r <= res_taken;
            rpc_r   <= res_target;
            link_r  <= res_link;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          rv_r    <= 1'b0;
          taken_r <= 1'b0;
          rpc_r   <= '0;
          link_r  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JUMP_RESOLVE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_taken       <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state == ST_WAIT) perf_wait_cycles <= perf_wait_cycles + 32'd1;
      if (state == ST_DONE && br_r && !flush) begin
        perf_branches <= perf_branches + 32'd1;
        if (taken_r) perf_taken <= perf_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jump_resolve_unit.sv
module tb_jump_resolve_unit;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int NUM_CDB = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     branch_issue, ujump_issue, flush;
  logic [3:0]               jump_op;
  logic [TAG_W-1:0]         q_rs1, q_rs2;
  logic [XLEN-1:0]          rs1_data, rs2_data, imm, pc;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_data;
  logic                     issue_ready, jump_stall, redirect_valid, redirect_taken;
  logic [XLEN-1:0]          redirect_pc, link_data;
`ifdef JUMP_RESOLVE_PERF_EN
  logic [31:0]              perf_branches, perf_taken, perf_wait_cycles;
`endif

  jump_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_issue(branch_issue), .ujump_issue(ujump_issue), .jump_op(jump_op),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
`ifdef JUMP_RESOLVE_PERF_EN
    .perf_branches(perf_branches), .perf_taken(perf_taken),
    .perf_wait_cycles(perf_wait_cycles),
`endif
    .issue_ready(issue_ready), .jump_stall(jump_stall),
    .redirect_valid(redirect_valid), .redirect_taken(redirect_taken),
    .redirect_pc(redirect_pc), .link_data(link_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br, uj;
    logic [3:0]  op;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  q1, q2;
    logic        exp_taken;
    logic [31:0] exp_pc, exp_link;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] tpc, link;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic br, logic uj, logic [3:0] op, logic [31:0] p,
                              logic [31:0] im, logic [4:0] q1, logic [4:0] q2,
                              logic [31:0] d1, logic [31:0] d2, logic t,
                              logic [31:0] epc, logic [31:0] elink);
    vec_t v;
    v.br = br; v.uj = uj; v.op = op; v.pc = p; v.imm = im;
    v.q1 = q1; v.q2 = q2; v.d1 = d1; v.d2 = d2;
    v.exp_taken = t; v.exp_pc = epc; v.exp_link = elink;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    branch_issue = 0; ujump_issue = 0; jump_op = 0; flush = 0;
    q_rs1 = 0; q_rs2 = 0; rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic drive(input vec_t v);
    branch_issue = v.br; ujump_issue = v.uj; jump_op = v.op;
    pc = v.pc; imm = v.imm; q_rs1 = v.q1; q_rs2 = v.q2;
    rs1_data = v.d1; rs2_data = v.d2;
  endtask

  task automatic push_exp(input logic t, input logic [31:0] tpc, input logic [31:0] link);
    exp_t e;
    e.taken = t; e.tpc = tpc; e.link = link;
    exp_q.push_back(e);
  endtask

  // Called at a negedge in the cycle a redirect is due
  task automatic check_redirect(input string name);
    exp_t e;
    chk({name, ".valid"}, 64'(redirect_valid), 64'd1);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s.scoreboard: got empty queue, required a pending entry", name);
    end else begin
      n_cmp--;
      e = exp_q.pop_front();
      chk({name, ".taken"}, 64'(redirect_taken), 64'(e.taken));
      chk({name, ".pc"},    64'(redirect_pc),    64'(e.tpc));
      chk({name, ".link"},  64'(link_data),      64'(e.link));
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 20 && !issue_ready; k++) @(negedge clk);
    if (!issue_ready) chk({name, ".idle_timeout"}, 64'(issue_ready), 64'd1);
  endtask

  // Branch with rs1 outstanding, resolved by bus1 two cycles after issue
  task automatic wait_seq(input string name, input logic [3:0] op, input logic t);
    vec_t v;
    v = mk(1, 0, op, 32'h200, 32'h40, 5'd3, 5'd0, 32'hFFFFFFFF, 32'd1, t, 32'h240, 32'h0);
    wait_idle(name);
    drive(v);
    push_exp(t, 32'h240, 32'h0);
    #1 chk({name, ".stall0"}, 64'(jump_stall), 64'd1);
    @(negedge clk);
    idle_inputs();
    cdb_valid = 2'b01; cdb_tag[4:0] = 5'd9; cdb_data[31:0] = 32'h1234;
    #1 chk({name, ".stall1"}, 64'(jump_stall), 64'd1);
    chk({name, ".valid1"}, 64'(redirect_valid), 64'd0);
    chk({name, ".ready1"}, 64'(issue_ready), 64'd0);
    @(negedge clk);
    idle_inputs();
    cdb_valid = 2'b10; cdb_tag[9:5] = 5'd3; cdb_data[63:32] = 32'hFFFFFFFE;
    #1 chk({name, ".stall2"}, 64'(jump_stall), 64'd1);
    chk({name, ".valid2"}, 64'(redirect_valid), 64'd0);
    @(negedge clk);
    idle_inputs();
    check_redirect(name);
    @(negedge clk);
    chk({name, ".pulse_end"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = mk(0,1,4'b0000,32'h100,32'h20,0,0,0,0,1,32'h120,32'h104);
    vecs[1]  = mk(1,0,4'b0000,32'h40,32'hFFFFFFF8,0,0,5,5,1,32'h38,0);
    vecs[2]  = mk(1,0,4'b0001,32'h40,32'hFFFFFFF8,0,0,5,5,0,32'h38,0);
    vecs[3]  = mk(1,0,4'b0100,32'h1000,32'h10,0,0,32'hFFFFFFFF,1,1,32'h1010,0);
    vecs[4]  = mk(1,0,4'b0101,32'h1000,32'h10,0,0,32'hFFFFFFFF,1,0,32'h1010,0);
    vecs[5]  = mk(1,0,4'b0110,32'h1000,32'h10,0,0,32'hFFFFFFFF,1,0,32'h1010,0);
    vecs[6]  = mk(1,0,4'b0111,32'h1000,32'h10,0,0,32'hFFFFFFFF,1,1,32'h1010,0);
    vecs[7]  = mk(1,0,4'b0010,32'h20,32'h4,0,0,1,2,0,32'h24,0);
    vecs[8]  = mk(1,0,4'b0011,32'h20,32'h4,0,0,1,1,0,32'h24,0);
    vecs[9]  = mk(0,1,4'b1000,32'h500,32'h10,0,5'd7,32'h1001,0,1,32'h1010,32'h504);
    vecs[10] = mk(0,1,4'b0000,32'hFFFFFFF0,32'h20,5'd3,5'd4,0,0,1,32'h10,32'hFFFFFFF4);
    vecs[11] = mk(1,1,4'b1000,32'h60,32'h4,0,0,7,7,1,32'h64,0);
    vecs[12] = mk(1,0,4'b0101,32'h80,32'h8,0,0,5,5,1,32'h88,0);
    vecs[13] = mk(1,0,4'b0100,32'h80,32'h8,0,0,5,5,0,32'h88,0);

    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("reset.ready", 64'(issue_ready), 64'd1);
    chk("reset.stall", 64'(jump_stall), 64'd0);
    chk("reset.valid", 64'(redirect_valid), 64'd0);
    chk("reset.taken", 64'(redirect_taken), 64'd0);
    chk("reset.pc", 64'(redirect_pc), 64'd0);
    chk("reset.link", 64'(link_data), 64'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      wait_idle($sformatf("vec%0d", i));
      drive(vecs[i]);
      push_exp(vecs[i].exp_taken, vecs[i].exp_pc, vecs[i].exp_link);
      #1 chk($sformatf("vec%0d.stall", i), 64'(jump_stall), 64'd0);
      @(negedge clk);
      idle_inputs();
      check_redirect($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d.pulse_end", i), 64'(redirect_valid), 64'd0);
      chk($sformatf("vec%0d.ready", i), 64'(issue_ready), 64'd1);
    end

    wait_seq("blt_wait", 4'b0100, 1'b1);
    wait_seq("bltu_wait", 4'b0110, 1'b0);

    // JALR: both buses carry tag 4 together, bus0 must win
    wait_idle("jalr_prio");
    drive(mk(0,1,4'b1000,32'h300,32'h0,5'd4,5'd6,32'hDEAD,0,1,0,0));
    push_exp(1, 32'h200, 32'h304);
    @(negedge clk);
    idle_inputs();
    cdb_valid = 2'b11; cdb_tag = {5'd4, 5'd4}; cdb_data = {32'h300, 32'h201};
    #1 chk("jalr_prio.stall", 64'(jump_stall), 64'd1);
    @(negedge clk);
    idle_inputs();
    check_redirect("jalr_prio");

    // JALR operand forwarded from the CDB in the capture cycle itself
    wait_idle("jalr_fwd");
    drive(mk(0,1,4'b1000,32'h700,32'h10,5'd4,5'd0,32'hDEAD,0,1,0,0));
    cdb_valid = 2'b10; cdb_tag = {5'd4, 5'd0}; cdb_data = {32'h501, 32'h0};
    push_exp(1, 32'h510, 32'h704);
    #1 chk("jalr_fwd.stall", 64'(jump_stall), 64'd0);
    @(negedge clk);
    idle_inputs();
    check_redirect("jalr_fwd");

    // Flush while waiting: entry squashed, no redirect even when its tag shows up
    wait_idle("flush_wait");
    drive(mk(1,0,4'b0000,32'h80,32'h4,5'd2,5'd0,0,0,0,0,0));
    @(negedge clk);
    idle_inputs();
    flush = 1;
    #1 chk("flush_wait.valid", 64'(redirect_valid), 64'd0);
    @(negedge clk);
    flush = 0;
    #1 chk("flush_wait.ready", 64'(issue_ready), 64'd1);
    seen = 0;
    cdb_valid = 2'b01; cdb_tag[4:0] = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (redirect_valid) seen = 1;
    end
    idle_inputs();
    chk("flush_wait.no_redirect", 64'(seen), 64'd0);

    // Flush coincident with DONE cancels the pulse
    @(negedge clk);
    drive(mk(0,1,4'b0000,32'h10,32'h8,0,0,0,0,0,0,0));
    @(negedge clk);
    idle_inputs();
    flush = 1;
    #1;
    chk("flush_done.valid", 64'(redirect_valid), 64'd0);
    chk("flush_done.taken", 64'(redirect_taken), 64'd0);
    chk("flush_done.pc", 64'(redirect_pc), 64'd0);
    chk("flush_done.link", 64'(link_data), 64'd0);
    @(negedge clk);
    flush = 0;
    #1 chk("flush_done.ready", 64'(issue_ready), 64'd1);

    // Flush with an issue in IDLE drops the issue
    @(negedge clk);
    drive(mk(0,1,4'b0000,32'h10,32'h8,0,0,0,0,0,0,0));
    flush = 1;
    @(negedge clk);
    idle_inputs();
    chk("flush_idle.valid", 64'(redirect_valid), 64'd0);
    chk("flush_idle.ready", 64'(issue_ready), 64'd1);

    // Reset while waiting discards the entry
    @(negedge clk);
    drive(mk(1,0,4'b0001,32'h90,32'h4,5'd5,5'd0,0,0,0,0,0));
    @(negedge clk);
    idle_inputs();
    chk("rst_wait.busy", 64'(issue_ready), 64'd0);
    #2 rst_n = 0;
    #1;
    chk("rst_wait.ready", 64'(issue_ready), 64'd1);
    chk("rst_wait.stall", 64'(jump_stall), 64'd0);
    chk("rst_wait.valid", 64'(redirect_valid), 64'd0);
    chk("rst_wait.pc", 64'(redirect_pc), 64'd0);
`ifdef JUMP_RESOLVE_PERF_EN
    chk("rst_wait.perf_branches", 64'(perf_branches), 64'd0);
    chk("rst_wait.perf_taken", 64'(perf_taken), 64'd0);
    chk("rst_wait.perf_wait", 64'(perf_wait_cycles), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cdb_valid = 2'b01; cdb_tag[4:0] = 5'd5;
    @(negedge clk);
    idle_inputs();
    chk("rst_wait.no_stale", 64'(redirect_valid), 64'd0);

    // Normal operation after reset
    drive(vecs[0]);
    push_exp(1, 32'h120, 32'h104);
    @(negedge clk);
    idle_inputs();
    check_redirect("post_reset");

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jump_resolve_unit.md
Name: jump_resolve_unit

Overview:
- Registered, parametrised branch/jump resolution station for the Tomasulo core.
- Accepts one issued conditional branch, JAL or JALR and holds it until its source operands are valid. Operands come from the register-status values at issue or from a snoop of NUM_CDB result buses.
- Once operands are valid it resolves the branch, computes target and link address, and issues a one-cycle redirect to the fetch/issue stage.
- Stalls issue while occupied. Replaces the combinational same-cycle-only jump path.

Parameters:
- XLEN, 32, datapath/PC width.
- TAG_W, 5, reservation tag width; tag 0 = operand ready.
- NUM_CDB, 2, number of common data buses snooped (1..4).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- branch_issue  in  1  conditional branch issued this cycle
- ujump_issue  in  1  JAL/JALR issued this cycle
- jump_op  in  4  [3]=JALR (ujump only), [2:0]=compare code (branch only)
- q_rs1, q_rs2  in  TAG_W each  producer tags at issue
- rs1_data, rs2_data  in  XLEN each  register values at issue
- imm, pc  in  XLEN each  immediate, instruction PC
- cdb_valid  in  NUM_CDB  per-bus valid
- cdb_tag  in  NUM_CDB*TAG_W  packed tags, bus i at [i*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*XLEN  packed data
- flush  in  1  squash held entry
- issue_ready  out  1  station can accept an issue
- jump_stall  out  1  hold the issue stage
- redirect_valid  out  1  one-cycle resolution pulse
- redirect_taken  out  1  redirect fetch to redirect_pc
- redirect_pc  out  XLEN  target
- link_data  out  XLEN  pc+4 for JAL/JALR, else 0

Behaviour:
- Reset is asynchronous on rst_n low. State=IDLE; all outputs 0 except issue_ready=1. Reset mid-WAIT discards the entry.
- States:
  - IDLE: issue_ready=1.
  - WAIT: entry held, operands outstanding.
  - DONE: redirect outputs registered, valid for exactly one cycle.
- IDLE, issue asserted (branch_issue or ujump_issue; both at once is illegal, branch_issue takes priority): capture op, pc, imm, tags and data.
- Operand forwarding at capture and on every WAIT cycle:
  - An operand is ready if its tag is 0 or it matches a valid CDB tag.
  - When several buses match, the lowest bus index wins.
  - A matched operand's tag is cleared to 0 and its data replaced.
- Operand requirements by op:
  - JAL needs no operand.
  - JALR needs rs1 only.
  - Branch needs rs1 and rs2.
  - An unneeded operand's tag is ignored.
- State transitions:
  - All needed operands ready in the capture cycle: IDLE->DONE (redirect_valid at issue cycle +1).
  - Otherwise: ->WAIT.
  - WAIT: when the last operand arrives on a CDB in cycle t, ->DONE and redirect_valid in cycle t+1.
  - DONE->IDLE unconditionally. A new issue is accepted in the IDLE cycle, not in DONE.
- Target and link:
  - Branch/JAL target = pc+imm. JALR target = (rs1+imm) with bit 0 cleared.
  - Adds are modulo 2^XLEN.
  - link_data = pc+4 for JAL/JALR, else 0.
- Taken rule: redirect_taken=1 for JAL/JALR. For a branch it equals the compare result.
- Compare codes: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Codes 010/011 give not-taken.
- jump_stall = (state!=IDLE) | (issue this cycle & needed operand not ready at capture). This is combinational from the issue inputs and the CDB.
- issue_ready = (state==IDLE).
- flush:
  - In WAIT or DONE: return to IDLE next cycle and suppress redirect_valid. A flush coincident with DONE cancels that pulse, so outputs read 0.
  - Flush in IDLE with an issue: the issue is dropped.

Optional Feature:
- Macro JUMP_RESOLVE_PERF_EN.
- When defined, adds outputs perf_branches, perf_taken and perf_wait_cycles, 32 bits each, reset 0.
  - perf_branches: incremented per resolved (non-flushed) conditional branch.
  - perf_taken: incremented per taken conditional branch.
  - perf_wait_cycles: incremented per cycle in WAIT.
  - All three wrap at 2^32.
- When undefined, these ports and their registers do not exist; other behaviour is identical.

Decomposition:
- Shared package/header jump_pkg: compare-code constants, state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), JALR bit index, and a tag-zero=ready constant.
- One sub-module, jru_cdb_snoop: a parametrised NUM_CDB priority matcher, instantiated once per operand. Inputs tag and packed CDB; outputs hit and data.

Test Plan:
- JAL, pc=0x100, imm=0x20, tags 0 → redirect_valid at +1, taken=1, redirect_pc=0x120, link_data=0x104, jump_stall=0 in the issue cycle.
- BEQ rs1=rs2=5, tags 0, pc=0x40, imm=-8 → taken=1, pc=0x38. BNE with the same operands → valid=1, taken=0.
- BLT, q_rs1=3, rs1=-1 (0xFFFFFFFF), rs2=1; CDB bus1 tag 3 data 0xFFFFFFFE at +2 → stall high cycles +0..+2, redirect at +3, taken=1. BLTU with the same values → taken=0.
- JALR, q_rs1=4; bus0 and bus1 both drive tag 4 in the same cycle with data 0x201 and 0x300, imm=0 → bus0 wins, redirect_pc=0x200.
- Branch waiting in WAIT, flush asserted → IDLE next cycle, redirect_valid never asserted, issue_ready=1.
- rst_n low while in WAIT → all outputs 0, issue_ready=1 immediately. With JUMP_RESOLVE_PERF_EN defined, counters read 0.
